mem_stage: RTL and testbench

//   Memory-access stage of the BasicVersion RISC-V core, directly downstream of execute.

---
 rtl/mem_stage_if.sv | 55 +++++
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Instruction record shared by execute and memory stages, plus the bundle of
// handshake/bus signals around the memory stage.
package ProcTypes;
    typedef enum logic [3:0] {
        OP, OPIMM, BRANCH, LUI, JAL, JALR, LOAD, STORE, AUIPC, Unsupported
    } IType;

    typedef enum logic [2:0] {
        Lw, Lh, Lhu, Lb, Lbu, Sw, Sh, Sb
    } MemFunc;

    typedef struct packed {
        IType        iType;
        MemFunc      memFunc;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] nextPc;
    } ExecInst;
endpackage

// master: the memory stage itself; slave: its surroundings (execute, dmem, writeback)
interface mem_stage_if;
    import ProcTypes::*;

    logic        in_valid;
    logic        in_ready;
    ExecInst     in_inst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_en;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        fault;

    modport master (
        input  in_valid, in_inst, mem_req_ready, mem_resp_valid, mem_rdata, wb_ready,
        output in_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
               wb_valid, wb_en, wb_dst, wb_data, fault
    );

    modport slave (
        output in_valid, in_inst, mem_req_ready, mem_resp_valid, mem_rdata, wb_ready,
        input  in_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
               wb_valid, wb_en, wb_dst, wb_data, fault
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one instruction in flight, loads/stores through a
// valid/ready data port, every instruction forwarded to writeback.
module mem_stage
    import ProcTypes::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input logic         clk_in,
    input logic         rst_in,
    mem_stage_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t      r_state;
    state_t      w_next;
    IType        r_itype;
    MemFunc      r_func;
    logic [1:0]  r_lane;
    logic [15:0] r_cnt;
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic        r_wb_en;
    logic [4:0]  r_wb_dst;
    logic [31:0] r_wb_data;
    logic        r_fault;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_nonmem_en;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [15:0] w_cnt_inc;
    logic        w_timeout;
    logic        w_unused_nextpc;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_is_mem  = (bus.in_inst.iType == LOAD) || (bus.in_inst.iType == STORE);
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_timeout = (TIMEOUT != '0) && (w_cnt_inc == TIMEOUT);
    assign w_unused_nextpc = ^bus.in_inst.nextPc;

    // Alignment check and writeback enable for the incoming instruction
    always_comb begin
        w_misaligned = 1'b0;
        w_nonmem_en  = 1'b0;
        case (bus.in_inst.memFunc)
            Lw, Sw:      w_misaligned = (bus.in_inst.addr[1:0] != 2'b00);
            Lh, Lhu, Sh: w_misaligned = bus.in_inst.addr[0];
            default:     w_misaligned = 1'b0;
        endcase
        case (bus.in_inst.iType)
            BRANCH, STORE, Unsupported: w_nonmem_en = 1'b0;
            default:                    w_nonmem_en = (bus.in_inst.dst != 5'd0);
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        w_wstrb = '0;
        w_wdata = '0;
        if (bus.in_inst.iType == STORE) begin
            case (bus.in_inst.memFunc)
                Sb: begin
                    w_wstrb = 4'b0001 << bus.in_inst.addr[1:0];
                    w_wdata = {4{bus.in_inst.data[7:0]}};
                end
                Sh: begin
                    w_wstrb = 4'b0011 << bus.in_inst.addr[1:0];
                    w_wdata = {2{bus.in_inst.data[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = bus.in_inst.data;
                end
            endcase
        end
    end

    // Load lane extraction with sign/zero extension
    always_comb begin
        w_shift    = bus.mem_rdata >> {r_lane, 3'b000};
        w_half     = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_load_val = bus.mem_rdata;
        case (r_func)
            Lb:      w_load_val = {{24{w_shift[7]}}, w_shift[7:0]};
            Lbu:     w_load_val = {24'd0, w_shift[7:0]};
            Lh:      w_load_val = {{16{w_half[15]}}, w_half};
            Lhu:     w_load_val = {16'd0, w_half};
            default: w_load_val = bus.mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_next = (w_is_mem && !w_misaligned) ? S_REQ : S_WB;
            S_REQ:  if (bus.mem_req_ready) w_next = (r_itype == STORE) ? S_WB : S_WAIT;
            S_WAIT: if (bus.mem_resp_valid || w_timeout) w_next = S_WB;
            S_WB:   if (bus.wb_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch instruction on accept, capture load result or timeout in WAIT
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_itype     <= OP;
            r_func      <= Lw;
            r_lane      <= '0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_wb_en     <= 1'b0;
            r_wb_dst    <= '0;
            r_wb_data   <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            if (w_accept) begin
                r_itype     <= bus.in_inst.iType;
                r_func      <= bus.in_inst.memFunc;
                r_lane      <= bus.in_inst.addr[1:0];
                r_cnt       <= '0;
                r_mem_addr  <= {bus.in_inst.addr[31:2], 2'b00};
                r_mem_we    <= (bus.in_inst.iType == STORE);
                r_mem_wstrb <= w_wstrb;
                r_mem_wdata <= w_wdata;
                r_wb_dst    <= bus.in_inst.dst;
                if (w_is_mem && w_misaligned) begin
                    r_wb_en   <= 1'b0;
                    r_wb_data <= '0;
                    r_fault   <= 1'b1;
                end else begin
                    r_wb_en   <= w_is_mem ? 1'b0 : w_nonmem_en;
                    r_wb_data <= bus.in_inst.data;
                end
            end
            if (r_state == S_WAIT) begin
                if (bus.mem_resp_valid) begin
                    r_wb_data <= w_load_val;
                    r_wb_en   <= (r_wb_dst != 5'd0);
                end else if (w_timeout) begin
                    r_wb_data <= '0;
                    r_wb_en   <= 1'b0;
                    r_fault   <= 1'b1;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign bus.in_ready      = (r_state == S_IDLE);
    assign bus.mem_req_valid = (r_state == S_REQ);
    assign bus.wb_valid      = (r_state == S_WB);
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_wstrb     = r_mem_wstrb;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.wb_en         = r_wb_en;
    assign bus.wb_dst        = r_wb_dst;
    assign bus.wb_data       = r_wb_data;
    assign bus.fault         = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writeback records are queued when
// an instruction is driven and popped when the stage presents writeback.
module tb_mem_stage;
    import ProcTypes::*;

    localparam logic [15:0] TMO = 16'd4;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
        logic        en;
        logic        fault;
    } wb_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    wb_rec_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic ExecInst mk(IType t, MemFunc f, logic [4:0] d, logic [31:0] data, logic [31:0] addr);
        ExecInst x;
        x.iType   = t;
        x.memFunc = f;
        x.dst     = d;
        x.data    = data;
        x.addr    = addr;
        x.nextPc  = addr + 32'd4;
        return x;
    endfunction

    function automatic wb_rec_t wr(logic [4:0] d, logic [31:0] data, logic en, logic flt);
        wb_rec_t r;
        r.dst = d; r.data = data; r.en = en; r.fault = flt;
        return r;
    endfunction

    function automatic logic [31:0] ld_model(MemFunc f, logic [1:0] a, logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f)
            Lb:  return {{24{b[7]}}, b};
            Lbu: return {24'd0, b};
            Lh:  return {{16{h[15]}}, h};
            Lhu: return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] st_strb(MemFunc f, logic [1:0] a);
        if (f == Sw) return 4'b1111;
        if (f == Sh) return a[1] ? 4'b1100 : 4'b0011;
        case (a)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] st_data(MemFunc f, logic [31:0] d);
        if (f == Sb) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f == Sh) return {d[15:0], d[15:0]};
        return d;
    endfunction

    task automatic mem_chk(input string name, input ExecInst x);
        check({name, ".req_valid"}, bus.mem_req_valid, 1);
        check({name, ".addr"}, bus.mem_addr, {x.addr[31:2], 2'b00});
        check({name, ".we"}, bus.mem_we, (x.iType == STORE));
        if (x.iType == STORE) begin
            check({name, ".wstrb"}, bus.mem_wstrb, st_strb(x.memFunc, x.addr[1:0]));
            check({name, ".wdata"}, bus.mem_wdata, st_data(x.memFunc, x.data));
        end else begin
            check({name, ".wstrb"}, bus.mem_wstrb, 0);
        end
    endtask

    // One full transaction: accept, optional memory phase, writeback with optional stall
    task automatic run_txn(input string name, input ExecInst x, input bit exp_req,
                           input int req_stall, input int resp_delay, input logic [31:0] rdata,
                           input int wb_stall, input wb_rec_t exp, input bit chk_data,
                           input int exp_lat);
        int      acc;
        bit      got;
        wb_rec_t e;
        bus.in_inst  = x;
        bus.in_valid = 1'b1;
        bus.wb_ready = (wb_stall == 0);
        sb_q.push_back(exp);
        @(negedge clk);
        check({name, ".in_ready"}, bus.in_ready, 1);
        acc = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (exp_req) begin
            for (int i = 0; i < req_stall; i++) begin
                bus.mem_req_ready = 1'b0;
                @(negedge clk);
                mem_chk({name, ".stall"}, x);
                @(posedge clk); #1;
            end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            mem_chk(name, x);
            @(posedge clk); #1;
            bus.mem_req_ready = 1'b0;
            if (x.iType == LOAD && resp_delay >= 0) begin
                for (int i = 0; i < resp_delay; i++) begin
                    @(negedge clk);
                    check({name, ".wait_wb"}, bus.wb_valid, 0);
                    @(posedge clk); #1;
                end
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata      = rdata;
                @(posedge clk); #1;
                bus.mem_resp_valid = 1'b0;
                bus.mem_rdata      = $urandom;
            end
        end
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.wb_valid) begin
                got = 1'b1;
                break;
            end
            check({name, ".no_req"}, bus.mem_req_valid, 0);
            @(posedge clk); #1;
        end
        if (!got) begin
            check({name, ".wb_never_valid"}, 0, 1);
            void'(sb_q.pop_front());
            bus.wb_ready = 1'b1;
            @(posedge clk); #1;
            return;
        end
        check({name, ".latency"}, cyc - acc, exp_lat);
        check({name, ".fault"}, bus.fault, exp.fault);
        if (sb_q.size() == 0) begin
            check({name, ".sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check({name, ".dst"}, bus.wb_dst, e.dst);
        check({name, ".en"}, bus.wb_en, e.en);
        if (chk_data) check({name, ".data"}, bus.wb_data, e.data);
        for (int s = 1; s < wb_stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({name, ".hold_valid"}, bus.wb_valid, 1);
            check({name, ".hold_in_ready"}, bus.in_ready, 0);
            check({name, ".hold_fault"}, bus.fault, 0);
            check({name, ".hold_data"}, bus.wb_data, e.data);
            check({name, ".hold_en"}, bus.wb_en, e.en);
        end
        if (wb_stall > 0) begin
            @(posedge clk); #1;
            bus.wb_ready = 1'b1;
            @(negedge clk);
            check({name, ".hs_valid"}, bus.wb_valid, 1);
            check({name, ".hs_in_ready"}, bus.in_ready, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check({name, ".idle_valid"}, bus.wb_valid, 0);
        check({name, ".idle_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        ExecInst     x;
        int          k;
        int          stall;
        int          rdly;
        logic [4:0]  d;
        logic [31:0] dat;
        logic [31:0] rd;
        logic [31:0] base;
        logic [1:0]  lane;
        MemFunc      f;

        bus.in_valid       = 1'b0;
        bus.in_inst        = mk(OP, Lw, 5'd0, 32'd0, 32'd0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        bus.wb_ready       = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.req_valid", bus.mem_req_valid, 0);
        check("rst.wb_valid", bus.wb_valid, 0);
        check("rst.fault", bus.fault, 0);
        check("rst.wb_data", bus.wb_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn("op_stall", mk(OP, Lw, 5'd5, 32'h7, 32'h0), 0, 0, 0, 0, 2, wr(5'd5, 32'h7, 1, 0), 1, 1);
        run_txn("lb", mk(LOAD, Lb, 5'd3, 32'h0, 32'h1003), 1, 0, 0, 32'h80112233, 0,
                wr(5'd3, 32'hFFFFFF80, 1, 0), 1, 3);
        run_txn("lhu", mk(LOAD, Lhu, 5'd4, 32'h0, 32'h2002), 1, 0, 2, 32'hBEEF0000, 0,
                wr(5'd4, 32'h0000BEEF, 1, 0), 1, 5);
        run_txn("sb11", mk(STORE, Sb, 5'd0, 32'hAB, 32'h11), 1, 3, 0, 0, 0, wr(5'd0, 0, 0, 0), 0, 5);
        run_txn("sb12", mk(STORE, Sb, 5'd2, 32'hAB, 32'h12), 1, 0, 0, 0, 0, wr(5'd2, 0, 0, 0), 0, 2);
        run_txn("sh", mk(STORE, Sh, 5'd1, 32'h1234CAFE, 32'h2), 1, 1, 0, 0, 0, wr(5'd1, 0, 0, 0), 0, 3);
        run_txn("sw", mk(STORE, Sw, 5'd9, 32'hDEADBEEF, 32'h100), 1, 0, 0, 0, 0, wr(5'd9, 0, 0, 0), 0, 2);
        run_txn("lw_mis", mk(LOAD, Lw, 5'd7, 32'h0, 32'h6), 0, 0, 0, 0, 0, wr(5'd7, 0, 0, 1), 0, 1);
        run_txn("lh_mis", mk(LOAD, Lh, 5'd7, 32'h0, 32'h1), 0, 0, 0, 0, 0, wr(5'd7, 0, 0, 1), 0, 1);
        run_txn("sh_mis", mk(STORE, Sh, 5'd7, 32'h55, 32'h3), 0, 0, 0, 0, 0, wr(5'd7, 0, 0, 1), 0, 1);
        run_txn("lw_x0", mk(LOAD, Lw, 5'd0, 32'h0, 32'h40), 1, 0, 1, 32'h12345678, 0,
                wr(5'd0, 32'h12345678, 0, 0), 1, 4);
        run_txn("lh_neg", mk(LOAD, Lh, 5'd10, 32'h0, 32'h82), 1, 0, 0, 32'h80010000, 0,
                wr(5'd10, 32'hFFFF8001, 1, 0), 1, 3);
        run_txn("lbu", mk(LOAD, Lbu, 5'd11, 32'h0, 32'h81), 1, 0, 0, 32'h0000F000, 0,
                wr(5'd11, 32'h000000F0, 1, 0), 1, 3);
        run_txn("jal", mk(JAL, Lw, 5'd1, 32'h104, 32'h0), 0, 0, 0, 0, 0, wr(5'd1, 32'h104, 1, 0), 1, 1);
        run_txn("branch", mk(BRANCH, Lw, 5'd3, 32'h1, 32'h0), 0, 0, 0, 0, 0, wr(5'd3, 32'h1, 0, 0), 1, 1);
        run_txn("unsup", mk(Unsupported, Lw, 5'd9, 32'h5, 32'h0), 0, 0, 0, 0, 0, wr(5'd9, 32'h5, 0, 0), 1, 1);
        run_txn("op_x0", mk(OP, Lw, 5'd0, 32'h99, 32'h0), 0, 0, 0, 0, 0, wr(5'd0, 32'h99, 0, 0), 1, 1);
        run_txn("timeout", mk(LOAD, Lw, 5'd6, 32'h0, 32'h300), 1, 0, -1, 0, 0,
                wr(5'd6, 32'h0, 0, 1), 1, 2 + int'(TMO));

        for (int i = 0; i < 24; i++) begin
            k     = $urandom_range(0, 3);
            d     = 5'($urandom_range(0, 31));
            dat   = $urandom;
            rd    = $urandom;
            base  = $urandom & 32'hFFFF_FFFC;
            stall = $urandom_range(0, 2);
            rdly  = $urandom_range(0, 2);
            if (k == 1) f = MemFunc'($urandom_range(0, 4));
            else        f = MemFunc'($urandom_range(5, 7));
            case (f)
                Lw, Sw:      lane = 2'd0;
                Lh, Lhu, Sh: lane = {1'($urandom_range(0, 1)), 1'b0};
                default:     lane = 2'($urandom_range(0, 3));
            endcase
            x = mk(OP, f, d, dat, base | {30'd0, lane});
            case (k)
                0: run_txn("rnd_op", x, 0, 0, 0, 0, 0, wr(d, dat, d != 0, 0), 1, 1);
                1: begin
                    x.iType = LOAD;
                    run_txn("rnd_ld", x, 1, 0, rdly, rd, 0,
                            wr(d, ld_model(f, lane, rd), d != 0, 0), 1, 3 + rdly);
                end
                2: begin
                    x.iType = STORE;
                    run_txn("rnd_st", x, 1, stall, 0, 0, 0, wr(d, 0, 0, 0), 0, 2 + stall);
                end
                default: begin
                    x.iType = JALR;
                    run_txn("rnd_jalr", x, 0, 0, 0, 0, 0, wr(d, dat, d != 0, 0), 1, 1);
                end
            endcase
        end

        // Reset while a load is waiting for its response; the late response must be dropped
        bus.in_inst  = mk(LOAD, Lw, 5'd8, 32'h0, 32'h500);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid      = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hCAFEF00D;
        @(negedge clk);
        check("midrst.in_ready", bus.in_ready, 1);
        check("midrst.req_valid", bus.mem_req_valid, 0);
        check("midrst.wb_valid", bus.wb_valid, 0);
        check("midrst.fault", bus.fault, 0);
        check("midrst.wb_en", bus.wb_en, 0);
        check("midrst.wb_dst", bus.wb_dst, 0);
        check("midrst.wb_data", bus.wb_data, 0);
        check("midrst.addr", bus.mem_addr, 0);
        check("midrst.we", bus.mem_we, 0);
        check("midrst.wstrb", bus.mem_wstrb, 0);
        check("midrst.wdata", bus.mem_wdata, 0);
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        check("late_resp.wb_valid", bus.wb_valid, 0);
        check("late_resp.in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        run_txn("after_rst", mk(OP, Lw, 5'd12, 32'h1234, 32'h0), 0, 0, 0, 0, 0,
                wr(5'd12, 32'h1234, 1, 0), 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
